// File: rtl/sa_input_feeder_if.sv
// Shared-SRAM read port seen by the SA input feeder.
// The feeder is the master; the SRAM/arbiter side is the slave.
interface sa_input_feeder_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
);
   logic              sram_rd_req;
   logic [ADDR_W-1:0] sram_rd_addr;
   logic              sram_rd_gnt;
   logic [DATA_W-1:0] sram_rd_data;

   modport master (
      output sram_rd_req,
      output sram_rd_addr,
      input  sram_rd_gnt,
      input  sram_rd_data
   );

   modport slave (
      input  sram_rd_req,
      input  sram_rd_addr,
      output sram_rd_gnt,
      output sram_rd_data
   );
endinterface

// File: rtl/sa_input_feeder.sv
// Fetches rows from shared SRAM and feeds the SA array, skewed per lane (activations) or direct (weights).
// Optional build macro SA_FEEDER_STALL_CNT_EN adds the stall_cycles counter output.
module sa_input_feeder #(
   parameter int ADDR_W = 10,
   parameter int DIM    = 4,
   parameter int LANE_W = 4,
   parameter int LEN_W  = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [LEN_W-1:0]        num_rows,
   input  logic                    weight_mode,
   sa_input_feeder_if.master       sram,
   output logic [DIM*LANE_W-1:0]   row_out,
   output logic                    row_valid,
   output logic [DIM-1:0]          load_weight_row,
   output logic                    busy,
   output logic                    done
`ifdef SA_FEEDER_STALL_CNT_EN
   ,
   output logic [15:0]             stall_cycles
`endif
);

   localparam int ROW_W = DIM * LANE_W;
   localparam int CNT_W = (DIM > 2) ? $clog2(DIM) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ADDR_W-1:0]  r_base;
   logic [LEN_W-1:0]   r_num_rows;
   logic               r_wmode;
   logic [LEN_W-1:0]   r_issued;
   logic               r_rvalid;
   logic [CNT_W-1:0]   r_drain_cnt;
   logic [DIM-1:0]     r_wsel;

   logic               w_req;
   logic               w_start_acc;
   logic               w_grant;
   logic               w_drain_adv;
   logic               w_adv;
   logic [ROW_W-1:0]   w_lane_in;
   logic [ROW_W-1:0]   w_tap;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_start_acc = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_state_nxt = (num_rows == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            busy  = 1'b1;
            w_req = (r_issued != r_num_rows);
            // Leave only once the final returned word has been registered onto row_out.
            if (!w_req && !r_rvalid) w_state_nxt = r_wmode ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (r_drain_cnt == CNT_W'(DIM - 1)) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_grant     = w_req & sram.sram_rd_gnt;
   assign w_drain_adv = (w_state_nxt == S_DRAIN);
   assign w_adv       = r_rvalid | w_drain_adv;
   assign w_lane_in   = w_drain_adv ? '0 : sram.sram_rd_data;

   assign sram.sram_rd_req  = w_req;
   assign sram.sram_rd_addr = r_base + ADDR_W'(r_issued);

   // Lane j sees j extra stages; w_tap holds the value each lane presents on the next advance.
   for (genvar j = 0; j < DIM; j++) begin : g_lane
      if (j == 0) begin : g_direct
         assign w_tap[0 +: LANE_W] = w_lane_in[0 +: LANE_W];
      end else begin : g_chain
         logic [j*LANE_W-1:0] r_chain;
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)
               r_chain <= '0;
            else if (w_adv && !r_wmode)
               r_chain <= (r_chain << LANE_W) | (j*LANE_W)'(w_lane_in[j*LANE_W +: LANE_W]);
         end
         assign w_tap[j*LANE_W +: LANE_W] = r_chain[(j-1)*LANE_W +: LANE_W];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_base          <= '0;
         r_num_rows      <= '0;
         r_wmode         <= 1'b0;
         r_issued        <= '0;
         r_rvalid        <= 1'b0;
         r_drain_cnt     <= '0;
         r_wsel          <= '0;
         row_out         <= '0;
         row_valid       <= 1'b0;
         load_weight_row <= '0;
      end else begin
         r_rvalid        <= w_grant;
         row_valid       <= w_adv;
         load_weight_row <= (r_rvalid && r_wmode) ? r_wsel : '0;
         if (w_start_acc) begin
            r_base      <= base_addr;
            r_num_rows  <= num_rows;
            r_wmode     <= weight_mode;
            r_issued    <= '0;
            r_drain_cnt <= '0;
            r_wsel      <= {{(DIM-1){1'b0}}, 1'b1};
         end else begin
            if (w_grant)     r_issued    <= r_issued + 1'b1;
            if (r_rvalid)    r_wsel      <= {r_wsel[DIM-2:0], r_wsel[DIM-1]};
            if (w_drain_adv) r_drain_cnt <= r_drain_cnt + 1'b1;
         end
         if (w_adv) row_out <= r_wmode ? sram.sram_rd_data : w_tap;
      end
   end

`ifdef SA_FEEDER_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_stall_cnt <= '0;
      else if (w_start_acc)
         r_stall_cnt <= '0;
      else if (w_req && !sram.sram_rd_gnt && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_sa_input_feeder.sv
// Directed bench for sa_input_feeder: skew, weight load, grant stalls, empty job, reset abort, address wrap.
// Build with SA_FEEDER_STALL_CNT_EN defined to also exercise stall_cycles.
module tb_sa_input_feeder;
   localparam int ADDR_W = 10;
   localparam int DIM    = 4;
   localparam int LANE_W = 4;
   localparam int LEN_W  = 8;
   localparam int ROW_W  = DIM * LANE_W;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  num_rows = '0;
   logic              weight_mode = 1'b0;
   logic [ROW_W-1:0]  row_out;
   logic              row_valid;
   logic [DIM-1:0]    load_weight_row;
   logic              busy;
   logic              done;
`ifdef SA_FEEDER_STALL_CNT_EN
   logic [15:0]       stall_cycles;
`endif

   sa_input_feeder_if #(.ADDR_W(ADDR_W), .DATA_W(ROW_W)) sram_if ();

   sa_input_feeder #(
      .ADDR_W(ADDR_W), .DIM(DIM), .LANE_W(LANE_W), .LEN_W(LEN_W)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .start           (start),
      .base_addr       (base_addr),
      .num_rows        (num_rows),
      .weight_mode     (weight_mode),
      .sram            (sram_if),
      .row_out         (row_out),
      .row_valid       (row_valid),
      .load_weight_row (load_weight_row),
      .busy            (busy),
      .done            (done)
`ifdef SA_FEEDER_STALL_CNT_EN
      ,
      .stall_cycles    (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   logic [ROW_W-1:0]  mem [2**ADDR_W];
   logic [ROW_W-1:0]  q_rows [$];
   logic [ROW_W-1:0]  q_exp [$];
   logic [DIM-1:0]    q_lw [$];
   logic [ADDR_W-1:0] q_addr [$];
   int n_tests = 0;
   int n_fail  = 0;
   int first_cyc, done_cyc, n_done, n_req, n_bad;

   // SRAM model: data one cycle after an accepted request; granted addresses are logged
   always @(posedge clk) begin
      if (sram_if.sram_rd_req && sram_if.sram_rd_gnt) begin
         sram_if.sram_rd_data <= mem[sram_if.sram_rd_addr];
         q_addr.push_back(sram_if.sram_rd_addr);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_row_valid"}, row_valid, 0);
      check({tag, "_row_out"}, row_out, 0);
      check({tag, "_lw"}, load_weight_row, 0);
      check({tag, "_req"}, sram_if.sram_rd_req, 0);
      check({tag, "_addr"}, sram_if.sram_rd_addr, 0);
`ifdef SA_FEEDER_STALL_CNT_EN
      check({tag, "_stall"}, stall_cycles, 0);
`endif
   endtask

   task automatic check_rows(input string tag);
      check({tag, "_nrows"}, q_rows.size(), q_exp.size());
      for (int i = 0; i < q_exp.size() && i < q_rows.size(); i++)
         check($sformatf("%s_row%0d", tag, i), q_rows[i], q_exp[i]);
   endtask

   task automatic start_job(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n, input logic wm);
      base_addr   = b;
      num_rows    = n;
      weight_mode = wm;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
   endtask

   // Cycle 0 is the first negedge after the start edge; runs until the cycle after done or max_cyc.
   task automatic run_job(input int stall_lo, input int stall_hi, input int restart_cyc, input int max_cyc);
      logic [ROW_W-1:0]  last_row = '0;
      logic [ADDR_W-1:0] prev_addr = '0;
      bit                have_last = 0;
      q_rows.delete();
      q_lw.delete();
      q_addr.delete();
      first_cyc = -1;
      done_cyc  = -1;
      n_done    = 0;
      n_req     = 0;
      n_bad     = 0;
      for (int c = 0; c < max_cyc; c++) begin
         sram_if.sram_rd_gnt = !(c >= stall_lo && c <= stall_hi);
         if (c == restart_cyc) begin
            base_addr   = '0;
            num_rows    = 8'd7;
            weight_mode = 1'b1;
            start       = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (sram_if.sram_rd_req) n_req++;
         if (c >= stall_lo && c <= stall_hi) begin
            if (!sram_if.sram_rd_req) n_bad++;
            if (c > stall_lo && sram_if.sram_rd_addr !== prev_addr) n_bad++;
         end
         if (row_valid) begin
            q_rows.push_back(row_out);
            q_lw.push_back(load_weight_row);
            if (first_cyc < 0) first_cyc = c;
            last_row  = row_out;
            have_last = 1;
         end else begin
            if (have_last && row_out !== last_row) n_bad++;
            if (load_weight_row !== '0) n_bad++;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
            if (busy) n_bad++;
         end
         if (done_cyc >= 0 && c == done_cyc + 1) begin
            if (busy) n_bad++;
            break;
         end
         prev_addr = sram_if.sram_rd_addr;
         @(negedge clk);
      end
      start               = 1'b0;
      sram_if.sram_rd_gnt = 1'b1;
   endtask

   initial begin
      int seen_done;
      sram_if.sram_rd_gnt = 1'b1;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
      mem[10'h010] = 16'h4321; mem[10'h011] = 16'h8765; mem[10'h012] = 16'hCBA9;
      mem[10'h020] = 16'hA1B2; mem[10'h021] = 16'hC3D4; mem[10'h022] = 16'hE5F6; mem[10'h023] = 16'h0789;
      mem[10'h3FE] = 16'h1234; mem[10'h3FF] = 16'h5678; mem[10'h000] = 16'h9ABC;

      // Reset state
      repeat (2) @(negedge clk);
      check_quiet("reset");
      resetn = 1'b1;
      @(negedge clk);

      // Activation stream: skewed rows, then 3 drain rows, done next cycle
      start_job(10'h010, 8'd3, 1'b0);
      run_job(-1, -2, -1, 40);
      q_exp = '{16'h0001, 16'h0025, 16'h0369, 16'h47A0, 16'h8B00, 16'hC000};
      check_rows("act");
      check("act_first_cyc", first_cyc, 2);
      check("act_done_cyc", done_cyc, 8);
      check("act_n_done", n_done, 1);
      check("act_protocol", n_bad, 0);
      check("act_n_addr", q_addr.size(), 3);
      if (q_addr.size() == 3) begin
         check("act_addr0", q_addr[0], 10'h010);
         check("act_addr2", q_addr[2], 10'h012);
      end
`ifdef SA_FEEDER_STALL_CNT_EN
      check("act_stall", stall_cycles, 0);
`endif

      // Weight load: unskewed rows, rotating one-hot strobe, no drain
      start_job(10'h020, 8'd4, 1'b1);
      run_job(-1, -2, -1, 40);
      q_exp = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0789};
      check_rows("wgt");
      check("wgt_n_lw", q_lw.size(), 4);
      if (q_lw.size() == 4) begin
         check("wgt_lw0", q_lw[0], 4'b0001);
         check("wgt_lw1", q_lw[1], 4'b0010);
         check("wgt_lw2", q_lw[2], 4'b0100);
         check("wgt_lw3", q_lw[3], 4'b1000);
      end
      check("wgt_first_cyc", first_cyc, 2);
      check("wgt_done_cyc", done_cyc, 6);
      check("wgt_protocol", n_bad, 0);

      // Grant withheld for cycles 1..3: same rows, stretched timing
      start_job(10'h010, 8'd3, 1'b0);
      run_job(1, 3, -1, 40);
      q_exp = '{16'h0001, 16'h0025, 16'h0369, 16'h47A0, 16'h8B00, 16'hC000};
      check_rows("stall");
      check("stall_first_cyc", first_cyc, 2);
      check("stall_done_cyc", done_cyc, 11);
      check("stall_protocol", n_bad, 0);
      check("stall_n_addr", q_addr.size(), 3);
`ifdef SA_FEEDER_STALL_CNT_EN
      check("stall_cnt", stall_cycles, 3);
`endif

      // Empty job
      start_job(10'h100, 8'd0, 1'b0);
      run_job(-1, -2, -1, 20);
      check("empty_done_cyc", done_cyc, 0);
      check("empty_n_req", n_req, 0);
      check("empty_nrows", q_rows.size(), 0);
      check("empty_protocol", n_bad, 0);

      // Reset asserted in the middle of DRAIN
      start_job(10'h010, 8'd3, 1'b0);
      repeat (6) @(negedge clk);
      check("rst_mid_busy", busy, 1);
      check("rst_mid_valid", row_valid, 1);
      resetn = 1'b0;
      #1;
      check_quiet("rst_abort");
      seen_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      check("rst_no_done", seen_done, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Address wrap, with a start pulse during busy that must be ignored
      start_job(10'h3FE, 8'd3, 1'b0);
      run_job(-1, -2, 3, 40);
      q_exp = '{16'h0004, 16'h0038, 16'h027C, 16'h16B0, 16'h5A00, 16'h9000};
      check_rows("wrap");
      check("wrap_n_addr", q_addr.size(), 3);
      if (q_addr.size() == 3) begin
         check("wrap_addr0", q_addr[0], 10'h3FE);
         check("wrap_addr1", q_addr[1], 10'h3FF);
         check("wrap_addr2", q_addr[2], 10'h000);
      end
      check("wrap_n_req", n_req, 3);
      check("wrap_done_cyc", done_cyc, 8);
      check("wrap_n_done", n_done, 1);
      check("wrap_protocol", n_bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
